// File: rtl/kid_pkg.sv
// Shared types, default motion constants and clamped-step helpers for the kid sprite controller.
package kid_pkg;

  localparam logic [1:0] ST_GROUND = 2'b00;
  localparam logic [1:0] ST_RISE   = 2'b01;
  localparam logic [1:0] ST_FALL   = 2'b10;

  typedef enum logic [1:0] {
    GROUND = ST_GROUND,
    RISE   = ST_RISE,
    FALL   = ST_FALL
  } air_state_t;

  localparam logic [3:0] KID_JUMP_V    = 4'd7;
  localparam logic [3:0] KID_V_MAX     = 4'd8;
  localparam int         KID_G_PERIOD  = 2;
  localparam int         KID_MAX_JUMPS = 2;

  // Increase pos by step, saturating at lim; 11-bit sum avoids a 10-bit wrap.
  function automatic logic [9:0] inc_clamp(input logic [9:0] pos,
                                           input logic [9:0] step,
                                           input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[9:0];
  endfunction

  // Decrease pos by step, flooring at lim; compared before subtracting so it never wraps.
  function automatic logic [9:0] dec_clamp(input logic [9:0] pos,
                                           input logic [9:0] step,
                                           input logic [9:0] lim);
    logic [10:0] floor_sum;
    floor_sum = {1'b0, lim} + {1'b0, step};
    return ({1'b0, pos} < floor_sum) ? lim : (pos - step);
  endfunction

endpackage

// File: rtl/kid_motion_jump_fsm.sv
// Vertical motion state machine: jump acceptance, rise/fall speed and frame-divided gravity.
module kid_jump_fsm
  import kid_pkg::*;
#(
  parameter logic [3:0] JUMP_V    = KID_JUMP_V,
  parameter logic [3:0] V_MAX     = KID_V_MAX,
  parameter int         G_PERIOD  = KID_G_PERIOD,
  parameter int         MAX_JUMPS = KID_MAX_JUMPS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_key_jump,
  input  logic       i_coll_down,
  input  logic       i_coll_up,
  output logic [1:0] o_air_state,
  output logic [3:0] o_vy,
  output logic       o_move_up,
  output logic       o_move_down,
  output logic [1:0] o_jumps_used
);

  localparam int GW = (G_PERIOD > 1) ? $clog2(G_PERIOD) : 1;

  air_state_t    r_state, w_state_nx;
  logic [3:0]    r_vy, w_vy_nx;
  logic [GW-1:0] r_gcnt, w_gcnt_nx;
  logic [1:0]    r_jumps, w_jumps_nx;
  logic          r_jump_prev;

  logic w_jump_edge;
  logic w_jump_ok;
  logic w_gstep;

  assign w_jump_edge = i_key_jump & ~r_jump_prev;
  assign w_jump_ok   = w_jump_edge && (int'(r_jumps) < MAX_JUMPS);
  assign w_gstep     = (r_gcnt == GW'(G_PERIOD - 1));

  always_comb begin
    w_state_nx  = r_state;
    w_vy_nx     = r_vy;
    w_gcnt_nx   = r_gcnt;
    w_jumps_nx  = r_jumps;
    o_move_up   = 1'b0;
    o_move_down = 1'b0;
    case (r_state)
      GROUND: begin
        w_gcnt_nx = '0;
        if (w_jump_ok) begin
          w_state_nx = RISE;
          w_vy_nx    = JUMP_V;
          w_jumps_nx = r_jumps + 2'd1;
        end else if (!i_coll_down) begin
          // Walking off a ledge spends the ground jump.
          w_state_nx = FALL;
          w_vy_nx    = 4'd1;
          w_jumps_nx = 2'd1;
        end else begin
          w_vy_nx = '0;
        end
      end
      RISE: begin
        if (w_jump_ok) begin
          // Re-launch restarts the gravity phase along with the speed.
          w_vy_nx    = JUMP_V;
          w_gcnt_nx  = '0;
          w_jumps_nx = r_jumps + 2'd1;
        end else if (i_coll_up) begin
          w_state_nx = FALL;
          w_vy_nx    = '0;
          w_gcnt_nx  = '0;
        end else begin
          o_move_up = 1'b1;
          if (w_gstep) begin
            w_gcnt_nx = '0;
            w_vy_nx   = r_vy - 4'd1;
            if (r_vy <= 4'd1) begin
              w_state_nx = FALL;
              w_vy_nx    = '0;
            end
          end else begin
            w_gcnt_nx = r_gcnt + 1'b1;
          end
        end
      end
      FALL: begin
        if (i_coll_down) begin
          w_gcnt_nx = '0;
          if (w_jump_ok) begin
            w_state_nx = RISE;
            w_vy_nx    = JUMP_V;
            w_jumps_nx = 2'd1;
          end else begin
            w_state_nx = GROUND;
            w_vy_nx    = '0;
            w_jumps_nx = '0;
          end
        end else if (w_jump_ok) begin
          w_state_nx = RISE;
          w_vy_nx    = JUMP_V;
          w_gcnt_nx  = '0;
          w_jumps_nx = r_jumps + 2'd1;
        end else begin
          o_move_down = 1'b1;
          if (w_gstep) begin
            w_gcnt_nx = '0;
            if (r_vy < V_MAX) w_vy_nx = r_vy + 4'd1;
          end else begin
            w_gcnt_nx = r_gcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = GROUND;
        w_vy_nx    = '0;
        w_gcnt_nx  = '0;
        w_jumps_nx = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= GROUND;
      r_vy        <= '0;
      r_gcnt      <= '0;
      r_jumps     <= '0;
      r_jump_prev <= 1'b0;
    end else if (i_tick) begin
      r_state     <= w_state_nx;
      r_vy        <= w_vy_nx;
      r_gcnt      <= w_gcnt_nx;
      r_jumps     <= w_jumps_nx;
      r_jump_prev <= i_key_jump;
    end
  end

  assign o_air_state  = r_state;
  assign o_vy         = r_vy;
  assign o_jumps_used = r_jumps;

endmodule

// File: rtl/kid_motion.sv
// Per-frame kid sprite position controller: walking with clamps plus the vertical jump FSM.
module kid_motion
  import kid_pkg::*;
#(
  parameter logic [9:0] X_INIT    = 10'd40,
  parameter logic [9:0] Y_INIT    = 10'd420,
  parameter logic [9:0] X_MIN     = 10'd15,
  parameter logic [9:0] X_MAX     = 10'd624,
  parameter logic [9:0] Y_MIN     = 10'd15,
  parameter logic [9:0] Y_MAX     = 10'd464,
  parameter logic [9:0] X_STEP    = 10'd2,
  parameter logic [3:0] JUMP_V    = KID_JUMP_V,
  parameter logic [3:0] V_MAX     = KID_V_MAX,
  parameter int         G_PERIOD  = KID_G_PERIOD,
  parameter int         MAX_JUMPS = KID_MAX_JUMPS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       is_collision_x_right,
  input  logic       is_collision_x_left,
  input  logic       is_collision_y_down,
  input  logic       is_collision_y_up,
  output logic [9:0] kid_x,
  output logic [9:0] kid_y,
  output logic       facing_left,
  output logic [1:0] air_state,
  output logic [1:0] jumps_used
);

  logic [9:0] r_x, r_y;
  logic       r_facing;

  logic [3:0] w_vy;
  logic       w_move_up, w_move_down;
  logic       w_walk_right, w_walk_left;

  kid_jump_fsm #(
    .JUMP_V    (JUMP_V),
    .V_MAX     (V_MAX),
    .G_PERIOD  (G_PERIOD),
    .MAX_JUMPS (MAX_JUMPS)
  ) u_fsm (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_tick       (frame_tick),
    .i_key_jump   (key_jump),
    .i_coll_down  (is_collision_y_down),
    .i_coll_up    (is_collision_y_up),
    .o_air_state  (air_state),
    .o_vy         (w_vy),
    .o_move_up    (w_move_up),
    .o_move_down  (w_move_down),
    .o_jumps_used (jumps_used)
  );

  assign w_walk_right = key_right & ~key_left;
  assign w_walk_left  = key_left & ~key_right;

  // Facing follows the pressed key even when the wall blocks the step.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x      <= X_INIT;
      r_facing <= 1'b0;
    end else if (frame_tick) begin
      if (w_walk_right) begin
        r_facing <= 1'b0;
        if (!is_collision_x_right) r_x <= inc_clamp(r_x, X_STEP, X_MAX);
      end else if (w_walk_left) begin
        r_facing <= 1'b1;
        if (!is_collision_x_left) r_x <= dec_clamp(r_x, X_STEP, X_MIN);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_y <= Y_INIT;
    end else if (frame_tick) begin
      if (w_move_up)
        r_y <= dec_clamp(r_y, {6'd0, w_vy}, Y_MIN);
      else if (w_move_down)
        r_y <= inc_clamp(r_y, {6'd0, w_vy}, Y_MAX);
    end
  end

  assign kid_x       = r_x;
  assign kid_y       = r_y;
  assign facing_left = r_facing;

endmodule
